dsram_responder: RTL and testbench

- Data-SRAM responder: the memory end of the pipeline's data_sram request interface (en / wen / addr / wdata).
- Holds a word-organised synchronous RAM with byte-lane writes.
- Returns read data to the MEM stage, with an optional configurable wait-state engine.
- In wait-state configurations it raises a stall request into the pipeline stall controller.
- Used as the on-chip data memory in simulation and in cache-less builds.

---
 rtl/dsram_responder_pkg.sv | 14 +
 rtl/dsram_bytewrite_ram.sv | 40 ++++
 rtl/dsram_responder.sv | 161 ++++++++++++++++
 tb/tb_dsram_responder.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsram_responder_pkg.sv
// Shared constants for the data-SRAM responder: wait-state limit and FSM encodings.
package dsram_responder_pkg;

    // Largest wait-state count the 4-bit access counter can express.
    localparam int DSRAM_WAIT_MAX = 15;

    typedef logic [1:0] dsram_state_t;

    // Wait-state FSM encodings.
    localparam logic [1:0] DSRAM_IDLE = 2'd0;
    localparam logic [1:0] DSRAM_BUSY = 2'd1;
    localparam logic [1:0] DSRAM_RESP = 2'd2;

endpackage

// File: rtl/dsram_bytewrite_ram.sv
// Word-organised synchronous RAM with per-byte write enables.
// Each byte lane is its own array so the tools can map lane enables onto
// block-RAM byte writes. Reads are registered and write-first: a read of the
// index being written returns the new lane data, other lanes the stored data.
module dsram_bytewrite_ram #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic [3:0]        we,
    input  logic [ADDR_W-1:0] widx,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] ridx,
    output logic [31:0]       rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [0:DEPTH-1];
            logic [7:0] rd_reg;

            // Lane write plus registered write-first read.
            always_ff @(posedge clk) begin
                if (we[gi]) begin
                    mem[widx] <= wdata[8*gi +: 8];
                end
                if (we[gi] && (widx == ridx)) begin
                    rd_reg <= wdata[8*gi +: 8];
                end else begin
                    rd_reg <= mem[ridx];
                end
            end

            assign rdata[8*gi +: 8] = rd_reg;
        end
    endgenerate

endmodule

// File: rtl/dsram_responder.sv
// Data-SRAM responder: memory end of the data_sram request interface.
// WAIT_CYCLES=0 gives a fully pipelined memory (one response per request,
// one cycle later). WAIT_CYCLES>0 runs an IDLE/BUSY/RESP engine that stalls
// the pipeline for WAIT_CYCLES+1 cycles per access and can be flushed.
module dsram_responder
    import dsram_responder_pkg::*;
#(
    parameter int                  ADDR_W      = 10,
    parameter logic [29-ADDR_W:0]  BASE_HI     = '0,
    parameter int                  WAIT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        rdata_valid,
    output logic        addr_err,
    output logic        stallreq_for_mem
);

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > DSRAM_WAIT_MAX) begin : g_bad_wait
        $error("dsram_responder: WAIT_CYCLES must be within 0..15");
    end

    logic [ADDR_W-1:0] req_idx;
    logic              req_in_range;
    logic [3:0]        ram_we;
    logic [ADDR_W-1:0] ram_idx;
    logic [31:0]       ram_wdata;
    logic [31:0]       ram_rdata;
    logic              resp_valid;
    logic              resp_err;
    logic [31:0]       rdata_hold_reg;

    assign req_idx      = data_sram_addr[ADDR_W+1:2];
    assign req_in_range = (data_sram_addr[31:ADDR_W+2] == BASE_HI);

    dsram_bytewrite_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .widx  (ram_idx),
        .wdata (ram_wdata),
        .ridx  (ram_idx),
        .rdata (ram_rdata)
    );

    generate
        if (WAIT_CYCLES == 0) begin : g_pipe
            logic valid_reg;
            logic err_reg;
            // Byte offset is the MEM stage's concern; flush cannot affect an
            // access that already completed at its request edge.
            logic unused_pipe;
            assign unused_pipe = ^{flush, data_sram_addr[1:0]};

            assign ram_we           = (data_sram_en && req_in_range && !rst) ? data_sram_wen : 4'b0000;
            assign ram_idx          = req_idx;
            assign ram_wdata        = data_sram_wdata;
            assign stallreq_for_mem = 1'b0;

            // Every accepted request produces a response flag the next cycle.
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg <= 1'b0;
                    err_reg   <= 1'b0;
                end else begin
                    valid_reg <= data_sram_en;
                    err_reg   <= data_sram_en && !req_in_range;
                end
            end

            assign resp_valid = valid_reg;
            assign resp_err   = err_reg;
        end else begin : g_fsm
            localparam logic [3:0] COUNT_INIT = 4'(WAIT_CYCLES - 1);

            dsram_state_t      state_reg;
            logic [3:0]        count_reg;
            logic [3:0]        wen_reg;
            logic [ADDR_W-1:0] idx_reg;
            logic [31:0]       wdata_reg;
            logic              err_reg;
            logic              access_now;
            logic              unused_fsm;
            assign unused_fsm = ^data_sram_addr[1:0];

            // The RAM is touched only on the last BUSY edge, and never when
            // that edge is being flushed or reset away.
            assign access_now = (state_reg == DSRAM_BUSY) && (count_reg == 4'd0) && !flush && !rst;
            assign ram_we     = (access_now && !err_reg) ? wen_reg : 4'b0000;
            assign ram_idx    = idx_reg;
            assign ram_wdata  = wdata_reg;

            assign stallreq_for_mem = ((state_reg == DSRAM_IDLE) && data_sram_en) || (state_reg == DSRAM_BUSY);
            assign resp_valid       = (state_reg == DSRAM_RESP);
            assign resp_err         = (state_reg == DSRAM_RESP) && err_reg;

            // Wait-state engine: latch in IDLE, count down in BUSY, respond in RESP.
            always_ff @(posedge clk) begin
                if (rst) begin
                    state_reg <= DSRAM_IDLE;
                    count_reg <= 4'd0;
                    wen_reg   <= 4'b0000;
                    idx_reg   <= '0;
                    wdata_reg <= 32'h0;
                    err_reg   <= 1'b0;
                end else begin
                    case (state_reg)
                        DSRAM_IDLE: begin
                            if (data_sram_en && !flush) begin
                                wen_reg   <= data_sram_wen;
                                idx_reg   <= req_idx;
                                wdata_reg <= data_sram_wdata;
                                err_reg   <= !req_in_range;
                                count_reg <= COUNT_INIT;
                                state_reg <= DSRAM_BUSY;
                            end
                        end
                        DSRAM_BUSY: begin
                            if (flush) begin
                                state_reg <= DSRAM_IDLE;
                            end else if (count_reg == 4'd0) begin
                                state_reg <= DSRAM_RESP;
                            end else begin
                                count_reg <= count_reg - 4'd1;
                            end
                        end
                        DSRAM_RESP: begin
                            // The still-asserted en belongs to the request just served.
                            state_reg <= DSRAM_IDLE;
                        end
                        default: begin
                            state_reg <= DSRAM_IDLE;
                        end
                    endcase
                end
            end
        end
    endgenerate

    // Read data is live only in a response cycle; otherwise the last value is held.
    assign data_sram_rdata = resp_valid ? (resp_err ? 32'h0 : ram_rdata) : rdata_hold_reg;
    assign rdata_valid     = resp_valid;
    assign addr_err        = resp_err;

    // Capture whatever is on rdata so it persists between responses.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_hold_reg <= 32'h0;
        end else begin
            rdata_hold_reg <= data_sram_rdata;
        end
    end

endmodule

// File: tb/tb_dsram_responder.sv
// Bench for dsram_responder: one pipelined instance (WAIT_CYCLES=0) and one
// wait-state instance (WAIT_CYCLES=3). Drivers push expected responses into
// per-instance queues computed from a word-array memory model; monitors pop
// and compare whenever rdata_valid is seen.
module tb_dsram_responder;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        en0 = 1'b0, flush0 = 1'b0;
    logic [3:0]  wen0 = 4'h0;
    logic [31:0] addr0 = 32'h0, wdata0 = 32'h0;
    logic [31:0] rdata0;
    logic        valid0, err0, stall0;

    logic        en3 = 1'b0, flush3 = 1'b0;
    logic [3:0]  wen3 = 4'h0;
    logic [31:0] addr3 = 32'h0, wdata3 = 32'h0;
    logic [31:0] rdata3;
    logic        valid3, err3, stall3;

    int n_cmp = 0;
    int n_bad = 0;

    exp_t q0[$];
    exp_t q3[$];
    logic [31:0] m0 [0:31];
    logic [31:0] m3 [0:31];

    always #5 clk = ~clk;

    dsram_responder #(.ADDR_W(10), .BASE_HI(20'h0), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush0),
        .data_sram_en(en0), .data_sram_wen(wen0), .data_sram_addr(addr0),
        .data_sram_wdata(wdata0), .data_sram_rdata(rdata0),
        .rdata_valid(valid0), .addr_err(err0), .stallreq_for_mem(stall0)
    );

    dsram_responder #(.ADDR_W(10), .BASE_HI(20'h0), .WAIT_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst), .flush(flush3),
        .data_sram_en(en3), .data_sram_wen(wen3), .data_sram_addr(addr3),
        .data_sram_wdata(wdata3), .data_sram_rdata(rdata3),
        .rdata_valid(valid3), .addr_err(err3), .stallreq_for_mem(stall3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference memory behaviour: lanes selected by wen take the new bytes.
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] wen);
        logic [31:0] mask;
        mask = {{8{wen[3]}}, {8{wen[2]}}, {8{wen[1]}}, {8{wen[0]}}};
        return (old & ~mask) | (nw & mask);
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        if ($urandom_range(0, 9) == 0) a = {20'($urandom_range(1, 20'hFFFFF)), 12'($urandom_range(0, 127))};
        else                           a = 32'($urandom_range(0, 127));
        return a;
    endfunction

    function automatic logic [3:0] rand_wen();
        logic [3:0] w;
        if ($urandom_range(0, 1) == 0) w = 4'h0;
        else                           w = 4'($urandom_range(1, 15));
        return w;
    endfunction

    // Pipelined instance: one request per call, back-to-back across calls.
    task automatic issue0(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        int   idx;
        en0 = 1'b1; wen0 = wen; addr0 = addr; wdata0 = wdata;
        idx = int'(addr[6:2]);
        if (addr[31:12] != 20'h0) begin
            e.data = 32'h0; e.err = 1'b1;
        end else begin
            m0[idx] = merge(m0[idx], wdata, wen);
            e.data = m0[idx]; e.err = 1'b0;
        end
        q0.push_back(e);
        @(posedge clk); #1;
    endtask

    task automatic idle0();
        en0 = 1'b0;
        @(posedge clk); #1;
    endtask

    // Wait-state instance: en held through the stall, as the MEM stage does.
    // flush_cyc=0: normal access; k>0: flush raised in the k-th BUSY cycle.
    task automatic access3(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata, input int flush_cyc);
        exp_t e;
        int   idx;
        int   cnt;
        en3 = 1'b1; wen3 = wen; addr3 = addr; wdata3 = wdata;
        if (flush_cyc == 0) begin
            idx = int'(addr[6:2]);
            if (addr[31:12] != 20'h0) begin
                e.data = 32'h0; e.err = 1'b1;
            end else begin
                m3[idx] = merge(m3[idx], wdata, wen);
                e.data = m3[idx]; e.err = 1'b0;
            end
            q3.push_back(e);
            cnt = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (!stall3) break;
                cnt++;
            end
            check("dut3_stall_cycles", 32'(cnt), 32'd4);
            check("dut3_valid_after_stall", 32'(valid3), 32'd1);
            @(posedge clk); #1;
            en3 = 1'b0;
        end else begin
            $display("dut3 flushed access addr=%h wen=%h in BUSY cycle %0d", addr, wen, flush_cyc);
            repeat (flush_cyc) @(posedge clk);
            #1 flush3 = 1'b1;
            @(posedge clk); #1;
            flush3 = 1'b0; en3 = 1'b0;
            @(negedge clk);
            check("dut3_stall_after_flush", 32'(stall3), 32'd0);
            @(posedge clk); #1;
        end
    endtask

    task automatic flush_accept3(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata);
        $display("dut3 flush in accept cycle addr=%h wen=%h", addr, wen);
        en3 = 1'b1; flush3 = 1'b1; wen3 = wen; addr3 = addr; wdata3 = wdata;
        @(posedge clk); #1;
        en3 = 1'b0; flush3 = 1'b0;
        @(negedge clk);
        check("dut3_accept_flush_stall", 32'(stall3), 32'd0);
        @(posedge clk); #1;
    endtask

    // Monitor for the pipelined instance.
    initial begin : mon0
        exp_t        e;
        logic [31:0] last;
        last = 32'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                last = 32'h0;
            end else begin
                check("dut0_stallreq", 32'(stall0), 32'd0);
                if (valid0) begin
                    if (q0.size() == 0) begin
                        check("dut0_unexpected_valid", 32'(valid0), 32'd0);
                    end else begin
                        e = q0.pop_front();
                        $display("dut0 resp rdata=%h err=%b (exp %h/%b)", rdata0, err0, e.data, e.err);
                        check("dut0_rdata", rdata0, e.data);
                        check("dut0_addr_err", 32'(err0), 32'(e.err));
                        last = e.data;
                    end
                end else begin
                    check("dut0_rdata_hold", rdata0, last);
                end
            end
        end
    end

    // Monitor for the wait-state instance.
    initial begin : mon3
        exp_t        e;
        logic [31:0] last;
        last = 32'h0;
        forever begin
            @(negedge clk);
            if (rst) begin
                last = 32'h0;
            end else if (valid3) begin
                if (q3.size() == 0) begin
                    check("dut3_unexpected_valid", 32'(valid3), 32'd0);
                end else begin
                    e = q3.pop_front();
                    $display("dut3 resp rdata=%h err=%b (exp %h/%b)", rdata3, err3, e.data, e.err);
                    check("dut3_rdata", rdata3, e.data);
                    check("dut3_addr_err", 32'(err3), 32'(e.err));
                    last = e.data;
                end
            end else begin
                check("dut3_rdata_hold", rdata3, last);
                check("dut3_addr_err_idle", 32'(err3), 32'd0);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [31:0] a;
        int          r;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_rdata0", rdata0, 32'h0);
        check("reset_valid0", 32'(valid0), 32'd0);
        check("reset_err0", 32'(err0), 32'd0);
        check("reset_rdata3", rdata3, 32'h0);
        check("reset_valid3", 32'(valid3), 32'd0);
        check("reset_stall3", 32'(stall3), 32'd0);
        @(posedge clk); #1;

        // ---------------- pipelined instance ----------------
        for (int i = 0; i < 32; i++) issue0(4'hF, 32'(i * 4), $urandom);
        issue0(4'hF, 32'h10, 32'hDEADBEEF);
        issue0(4'h0, 32'h10, 32'h0);
        issue0(4'b0100, 32'h10, 32'h00AA0000);
        issue0(4'h0, 32'h10, 32'h0);
        issue0(4'h0, 32'h12, 32'h0);
        idle0();
        issue0(4'hF, 32'h0001_0000, 32'hCAFEF00D);
        issue0(4'h0, 32'h0, 32'h0);
        issue0(4'h0, 32'h0001_0004, 32'h0);
        idle0(); idle0();

        // Reset coinciding with a write request: the write must be dropped.
        en0 = 1'b1; wen0 = 4'hF; addr0 = 32'h14; wdata0 = 32'h5555AAAA; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; en0 = 1'b0;
        idle0();
        issue0(4'h0, 32'h14, 32'h0);

        for (int i = 0; i < 200; i++) begin
            issue0(rand_wen(), rand_addr(), $urandom);
            if ($urandom_range(0, 3) == 0) idle0();
        end
        repeat (4) idle0();

        // ---------------- wait-state instance ----------------
        for (int i = 0; i < 32; i++) access3(4'hF, 32'(i * 4), $urandom, 0);
        access3(4'h0, 32'h10, 32'h0, 0);
        access3(4'hF, 32'h20, 32'h12345678, 2);
        repeat (3) @(posedge clk); #1;
        access3(4'h0, 32'h20, 32'h0, 0);
        flush_accept3(4'hF, 32'h24, 32'hA5A5A5A5);
        access3(4'h0, 32'h24, 32'h0, 0);
        access3(4'hF, 32'h28, 32'h0BADF00D, 3);
        access3(4'h0, 32'h28, 32'h0, 0);
        access3(4'hF, 32'h0001_0000, 32'h11112222, 0);
        access3(4'h0, 32'h0, 32'h0, 0);

        // Reset in the first BUSY cycle of a write.
        en3 = 1'b1; wen3 = 4'hF; addr3 = 32'h30; wdata3 = 32'h77778888;
        @(posedge clk); #1;
        rst = 1'b1; en3 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy_valid3", 32'(valid3), 32'd0);
        check("rst_busy_rdata3", rdata3, 32'h0);
        check("rst_busy_err3", 32'(err3), 32'd0);
        check("rst_busy_stall3", 32'(stall3), 32'd0);
        @(posedge clk); #1;
        access3(4'h0, 32'h30, 32'h0, 0);

        for (int i = 0; i < 40; i++) begin
            a = rand_addr();
            r = int'($urandom_range(0, 9));
            if (r == 0)      flush_accept3(rand_wen(), a, $urandom);
            else if (r < 3)  access3(rand_wen(), a, $urandom, int'($urandom_range(1, 3)));
            else             access3(rand_wen(), a, $urandom, 0);
            if ($urandom_range(0, 2) == 0) begin
                @(posedge clk); #1;
            end
        end

        repeat (5) @(posedge clk);
        #1;
        check("dut0_queue_drained", 32'(q0.size()), 32'd0);
        check("dut3_queue_drained", 32'(q3.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
